// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN (port 0 always wins on contention).
package dmem_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } dmem_arb_state_t;

    // One request as presented by a port, at the default bus widths.
    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

    // The port that is not 'id'.
    function automatic logic other_port(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way request picker: round-robin by default, fixed port-0 priority
// when DMEM_ARB_FIXED_PRIO_EN is defined (the pointer ports then vanish).
module dmem_rr_pick
    import dmem_pkg::*;
(
    input  logic req0,
    input  logic req1,
`ifndef DMEM_ARB_FIXED_PRIO_EN
    input  logic ptr,
    output logic ptr_nxt,
`endif
    output logic valid,
    output logic winner
);

    // Select a winner; the pointer only moves when both ports contend.
    always_comb begin
        valid = req0 | req1;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        ptr_nxt = ptr;
        if (req0 && req1) begin
            winner  = ptr;
            ptr_nxt = other_port(ptr);
        end else if (req1) begin
            winner = PORT1;
        end else begin
            winner = PORT0;
        end
`else
        if (req0) begin
            winner = PORT0;
        end else if (req1) begin
            winner = PORT1;
        end else begin
            winner = PORT0;
        end
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for an edge-triggered data memory. Each access
// is IDLE -> STROBE -> WAIT (MEM_LAT cycles) -> RESP, so the memory strobe is
// a single clean pulse that always rises from 0.
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN (fixed priority, no rr pointer).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              busy
);

    localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    dmem_arb_state_t   state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              win_q, win_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              busy_q, busy_d;
    logic              pick_valid;
    logic              pick_win;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic              rr_ptr_q, rr_ptr_d;
    logic              pick_ptr_nxt;
`endif

    dmem_rr_pick u_pick (
        .req0    (m0_req),
        .req1    (m1_req),
`ifndef DMEM_ARB_FIXED_PRIO_EN
        .ptr     (rr_ptr_q),
        .ptr_nxt (pick_ptr_nxt),
`endif
        .valid   (pick_valid),
        .winner  (pick_win)
    );

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        we_d     = we_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        gnt_d    = 2'b00;
        rvalid_d = 2'b00;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = STROBE;
                    win_d   = pick_win;
                    if (pick_win == PORT1) begin
                        we_d    = m1_we;
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                        gnt_d   = 2'b10;
                    end else begin
                        we_d    = m0_we;
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                        gnt_d   = 2'b01;
                    end
                    // Exactly one strobe, asserted in the STROBE cycle only.
                    rd_d = ~we_d;
                    wr_d = we_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                    rr_ptr_d = pick_ptr_nxt;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            STROBE: begin
                state_d = WAIT;
                cnt_d   = CNT_LOAD;
            end
            WAIT: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d  = RESP;
                    rvalid_d = (win_q == PORT1) ? 2'b10 : 2'b01;
                    if (!we_q) begin
                        rdata_d = mem_readdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RESP: begin
                // Any request still high here waits for the IDLE cycle.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= {DATA_W{1'b0}};
            rdata_q  <= {DATA_W{1'b0}};
            we_q     <= 1'b0;
            win_q    <= PORT0;
            cnt_q    <= CNT_ZERO;
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            busy_q   <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            rr_ptr_q <= PORT0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            busy_q   <= busy_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign m0_gnt        = gnt_q[0];
    assign m1_gnt        = gnt_q[1];
    assign m0_rvalid     = rvalid_q[0];
    assign m1_rvalid     = rvalid_q[1];
    assign rsp_rdata     = rdata_q;
    assign mem_address   = addr_q;
    assign mem_writeData = wdata_q;
    assign mem_read      = rd_q;
    assign mem_write     = wr_q;
    assign busy          = busy_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the edge-triggered data memory, which reads and writes on the rising edge of memRead/memWrite.
- Accepts load/store requests from port 0 (CPU load/store) and port 1 (DMA/debug), and picks one per access by round-robin.
- Drives a single clean one-cycle read or write strobe with a stable address and data, then returns read data or a write acknowledge to the granted port.
- Guarantees that every strobe rises from 0, so the memory sees exactly one edge per access.

Parameters:
- ADDR_W, 32, width of address to memory and requesters.
- DATA_W, 32, width of read/write data.
- MEM_LAT, 2, cycles the address is held after the strobe before readdata is sampled (min 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m0_req  input  1  port 0 request; held with fields until m0_gnt.
- m0_we  input  1  port 0: 1=write, 0=read.
- m0_addr  input  ADDR_W  port 0 address.
- m0_wdata  input  DATA_W  port 0 write data.
- m0_gnt  output  1  port 0 request accepted (1-cycle pulse).
- m0_rvalid  output  1  port 0 access complete; rsp_rdata valid if read (1-cycle pulse).
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid: same as port 0, for port 1.
- rsp_rdata  output  DATA_W  read data of the most recent completed read.
- mem_address  output  ADDR_W  to memory address.
- mem_writeData  output  DATA_W  to memory writeData.
- mem_read  output  1  to memory memRead.
- mem_write  output  1  to memory memWrite.
- mem_readdata  input  DATA_W  from memory readdata.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0): state=IDLE, all gnt/rvalid/mem_read/mem_write/busy=0, mem_address/mem_writeData/rsp_rdata=0, rr_ptr=0 (port 0 preferred).
- FSM states: IDLE -> STROBE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req is high, choose a winner, latch its addr/wdata/we into mem_address/mem_writeData/we_q, record the winner id, and go to STROBE.
  - With no req, stay in IDLE.
- Arbitration:
  - If only one port requests, it wins.
  - If both request, the port selected by rr_ptr wins; rr_ptr then points to the other port.
  - rr_ptr changes only on a grant.
- STROBE (1 cycle): winner gnt=1. mem_read=~we_q, mem_write=we_q; never both at once.
- WAIT (MEM_LAT cycles, down-counter):
  - Strobes are 0; address and data are held.
  - On the final WAIT edge, rsp_rdata is loaded from mem_readdata if the access is a read; it is unchanged on a write.
- RESP (1 cycle): winner rvalid=1, address still held, then IDLE.
- Latency:
  - gnt is high 1 cycle after the sampling edge.
  - rvalid is high 2+MEM_LAT cycles after the sampling edge.
  - Back-to-back accesses complete every 3+MEM_LAT cycles (5 at default).
- Strobe spacing: mem_read/mem_write are low for at least MEM_LAT+2 cycles between strobes, so every access produces a fresh rising edge.
- A req still high in the RESP cycle is ignored; it is sampled again in IDLE. Requesters must drop req in the cycle after gnt, or they issue a new access.
- rsp_rdata holds its value until the next read completes.
- Reset mid-operation:
  - The in-flight access is abandoned and no rvalid is issued.
  - Strobes drop immediately; a write whose strobe has already risen is committed by the memory.
- mem_address is driven with the latched request address unchanged; word/byte scaling belongs to the memory.

Optional Feature:
- DMEM_ARB_FIXED_PRIO_EN defined: port 0 always wins when both request; rr_ptr is removed.
- Not defined: round-robin as above.

Decomposition:
- Shared package dmem_pkg holds:
  - typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} dmem_arb_state_t.
  - typedef struct {we, addr, wdata} dmem_req_t.
  - Port id constants PORT0=0, PORT1=1.
- One natural sub-module: dmem_rr_pick (2-way round-robin/fixed picker producing winner id and pointer update).

Test Plan:
- Reset mid-WAIT of a port 0 read at addr 0x10: mem_read=0 and state=IDLE immediately; no m0_rvalid; the next access is granted to port 0.
- Port 0 read from address 0x4, memory returns 0xDEADBEEF, MEM_LAT=2:
  - Expect m0_gnt at +1 and mem_read high for exactly 1 cycle.
  - Expect m0_rvalid at +4 with rsp_rdata=0xDEADBEEF.
- Port 1 write 0x0000_00A5 to address 0x8:
  - Expect mem_write high for 1 cycle with mem_address=0x8 and mem_writeData=0xA5, and m1_rvalid at +4.
  - A following port 1 read of 0x8 returns 0xA5.
- Both ports hold req continuously for 4 accesses: grants alternate 0,1,0,1 at a 5-cycle period. With DMEM_ARB_FIXED_PRIO_EN, all 4 go to port 0.
- Read (0x0) immediately followed by a write (0xC): mem_read and mem_write are never high together, and each rises from 0 after at least 4 low cycles.
- Write then read on port 0: rsp_rdata keeps the earlier read value through the write's m0_rvalid, then updates only on the read.
